// File: rtl/pipe_reg_stage.sv
// ============================================================================
//  Module   : pipe_reg_stage
//  Purpose  : One handshaked pipeline register slot (valid bit + data word).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_reg_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             v,
    output logic [WIDTH-1:0] d,
    output logic             rdy
);

    // An empty slot always accepts, which is what collapses bubbles under a stall.
    assign rdy = ~v | dn_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            d <= RESET_VAL;
        end else if (flush) begin
            v <= 1'b0;
        end else if (rdy) begin
            v <= up_valid;
            d <= up_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_reg_chain.sv
// ============================================================================
//  Module   : pipe_reg_chain
//  Purpose  : DEPTH-stage stallable delay line with valid/ready backpressure.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_reg_chain #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic             w_v      [DEPTH];
    logic [WIDTH-1:0] w_d      [DEPTH];
    logic             w_up_v   [DEPTH];
    logic [WIDTH-1:0] w_up_d   [DEPTH];
    logic             w_rdy    [DEPTH+1];
    logic [OCC_W-1:0] w_occ;

    // Ready ripples from the output back to the input; data/valid flow forward.
    assign w_rdy[DEPTH] = out_ready;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            if (i == 0) begin : g_head
                assign w_up_v[i] = in_valid;
                assign w_up_d[i] = in_data;
            end else begin : g_link
                assign w_up_v[i] = w_v[i-1];
                assign w_up_d[i] = w_d[i-1];
            end

            pipe_reg_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush),
                .up_valid (w_up_v[i]),
                .up_data  (w_up_d[i]),
                .dn_ready (w_rdy[i+1]),
                .v        (w_v[i]),
                .d        (w_d[i]),
                .rdy      (w_rdy[i])
            );
        end
    endgenerate

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(w_v[i]);
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = w_v[DEPTH-1];
    assign out_data  = w_d[DEPTH-1];
    assign occupancy = w_occ;

endmodule

`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
// ============================================================================
//  Module   : tb_pipe_reg_chain
//  Purpose  : Self-checking bench for pipe_reg_chain (DEPTH=4 and DEPTH=1).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_reg_chain;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a_flush = 0, a_in_valid = 0, a_out_ready = 0;
    logic [7:0] a_in_data = 0;
    logic       a_in_ready, a_out_valid;
    logic [7:0] a_out_data;
    logic [2:0] a_occ;

    logic       b_flush = 0, b_in_valid = 0, b_out_ready = 0;
    logic [7:0] b_in_data = 0;
    logic       b_in_ready, b_out_valid;
    logic [7:0] b_out_data;
    logic [0:0] b_occ;

    int n_cmp = 0;
    int n_err = 0;

    pipe_reg_chain #(.WIDTH(8), .DEPTH(D), .RESET_VAL(8'h00)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    pipe_reg_chain #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Reference model: in-flight words with the stage index they occupy, oldest first.
    typedef struct { logic [7:0] data; int pos; } ent_t;
    ent_t       mq[$];
    logic [7:0] got[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of chain A; compares against the model before and after the edge.
    task automatic step(input logic iv, input logic [7:0] id, input logic ordy,
                        input logic fl, input logic rs, output logic acc);
        ent_t nq[$];
        logic m_ir;
        a_in_valid = iv; a_in_data = id; a_out_ready = ordy; a_flush = fl; rst = rs;
        #4;
        m_ir = (mq.size() < D) || ordy;
        chk("in_ready", a_in_ready, m_ir);
        acc = iv && m_ir && !fl && !rs;
        if (a_out_valid && ordy && !fl && !rs) got.push_back(a_out_data);
        nq = {};
        if (!fl && !rs) begin
            foreach (mq[k]) begin
                int p = mq[k].pos;
                if (p == D-1) begin
                    if (!ordy) nq.push_back(mq[k]);
                end else begin
                    ent_t e = mq[k];
                    // k older words sit above p; a hole exists there if fewer than D-1-p.
                    if ((k < D-1-p) || ordy) e.pos = p + 1;
                    nq.push_back(e);
                end
            end
            if (acc) nq.push_back('{data: id, pos: 0});
        end
        @(posedge clk);
        mq = nq;
        #1;
        chk("occupancy", a_occ, mq.size());
        chk("out_valid", a_out_valid, (mq.size() > 0 && mq[0].pos == D-1));
        if (mq.size() > 0 && mq[0].pos == D-1) chk("out_data", a_out_data, mq[0].data);
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        int         occ;
        logic       ov;
        logic [7:0] od;
        logic       ir;
    } vec_t;
    vec_t tbl[9];

    initial begin
        logic       acc;
        logic [7:0] words[6];
        logic [7:0] bq[$];
        int         idx;
        int         acc_step;

        tbl[0] = '{1'b1, 8'hA1, 1'b0, 1, 1'b0, 8'h00, 1'b1};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 8'h00, 1'b1};
        tbl[3] = '{1'b1, 8'hA2, 1'b0, 2, 1'b1, 8'hA1, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 2, 1'b1, 8'hA1, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 2, 1'b1, 8'hA1, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 2, 1'b1, 8'hA1, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'hA2, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1};

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mq = {};
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 8'h00);
        chk("rst_occupancy", a_occ, 0);
        #1 chk("rst_in_ready", a_in_ready, 1);

        // Streaming at full rate
        got = {};
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44; words[4] = 8'h55;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, words[i], 1'b1, 1'b0, 1'b0, acc);
            chk("stream_accept", acc, 1);
            if (i == 3) begin
                chk("stream_lat_valid", a_out_valid, 1);
                chk("stream_lat_data", a_out_data, 8'h11);
            end
        end
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
        chk("stream_count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk("stream_order", got[i], words[i]);

        // Backpressure
        got = {};
        for (int i = 0; i < 6; i++) words[i] = 8'hC0 + 8'(i);
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            step(1'b1, words[idx < 6 ? idx : 5], 1'b0, 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        chk("bp_accepted", idx, 4);
        chk("bp_occupancy", a_occ, 4);
        chk("bp_in_ready_low", a_in_ready, 0);
        for (int c = 0; c < 12; c++) begin
            step(idx < 6, words[idx < 6 ? idx : 5], 1'b1, 1'b0, 1'b0, acc);
            if (acc) idx++;
            if (c == 5) chk("bp_no_dead_cycle", got.size(), 6);
        end
        chk("bp_count", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++) chk("bp_order", got[i], words[i]);

        // Bubble collapse (table-driven)
        for (int r = 0; r < 9; r++) begin
            step(tbl[r].iv, tbl[r].id, tbl[r].ordy, 1'b0, 1'b0, acc);
            chk("tbl_occupancy", a_occ, tbl[r].occ);
            chk("tbl_out_valid", a_out_valid, tbl[r].ov);
            if (tbl[r].ov) chk("tbl_out_data", a_out_data, tbl[r].od);
            chk("tbl_in_ready", a_in_ready, tbl[r].ir);
        end

        // Flush mid-stream
        got = {};
        for (int i = 0; i < 3; i++) step(1'b1, 8'hB1 + 8'(i), 1'b0, 1'b0, 1'b0, acc);
        chk("fl_pre_occ", a_occ, 3);
        step(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, acc);
        chk("fl_occ", a_occ, 0);
        chk("fl_out_valid", a_out_valid, 0);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
        chk("fl_nothing_out", got.size(), 0);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) step(1'b1, 8'hD1 + 8'(i), 1'b0, 1'b0, 1'b0, acc);
        chk("rs_pre_occ", a_occ, 3);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, acc);
        chk("rs_occ", a_occ, 0);
        chk("rs_out_valid", a_out_valid, 0);
        chk("rs_out_data", a_out_data, 8'h00);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
        chk("rs_nothing_out", got.size(), 0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 39) == 0), 1'b0, acc);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
        chk("rand_drained", a_occ, 0);

        // DEPTH=1 chain
        a_in_valid = 0; a_out_ready = 0;
        bq = {};
        b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 8'h50;
        #4;
        if (b_in_ready) bq.push_back(b_in_data);
        @(posedge clk); #1;
        chk("d1_occ_full", b_occ, 1);
        chk("d1_in_ready_stall", b_in_ready, 0);
        b_out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            b_in_data = 8'h60 + 8'(k);
            #4;
            chk("d1_in_ready", b_in_ready, 1);
            chk("d1_out_valid", b_out_valid, 1);
            if (b_out_valid) begin
                if (bq.size() == 0) chk("d1_unexpected", 1, 0);
                else chk("d1_data", b_out_data, bq.pop_front());
            end
            if (b_in_ready) bq.push_back(b_in_data);
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        #4;
        if (b_out_valid && bq.size() > 0) chk("d1_data", b_out_data, bq.pop_front());
        @(posedge clk); #1;
        chk("d1_no_loss", bq.size(), 0);
        chk("d1_empty", b_occ, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
